// File: rtl/nfc_command_arbiter.sv
// nfc_command_arbiter
// Shares one address/command generator (ACG) between several NAND command
// modules. A module claims the ACG by raising its decoded-start flag while
// the arbiter is idle. The lowest index wins. The owner drives the shared
// bundle until it reports its last step or the BUSY watchdog expires. One
// DRAIN cycle then returns the bundle to its idle value before the next
// host command is accepted.

module nfc_command_arbiter #(
    parameter int          NumberOfWays  = 4,
    parameter int          NumberOfCmds  = 4,
    parameter logic [15:0] TimeoutCycles = 16'hFFFF
) (
    input  logic                           iSystemClock,
    input  logic                           iReset_n,
    input  logic                           iCMDValid,
    output logic                           oCMDReady,
    output logic [NumberOfCmds-1:0]        oCMDValid,
    input  logic [NumberOfCmds-1:0]        iStart,
    input  logic [NumberOfCmds-1:0]        iLastStep,
    input  logic [NumberOfCmds*8-1:0]      iCmd_Command,
    input  logic [NumberOfCmds*3-1:0]      iCmd_CommandOption,
    input  logic [NumberOfCmds*NumberOfWays-1:0] iCmd_TargetWay,
    input  logic [NumberOfCmds*16-1:0]     iCmd_NumOfData,
    input  logic [NumberOfCmds-1:0]        iCmd_CASelect,
    input  logic [NumberOfCmds*40-1:0]     iCmd_CAData,
    output logic [7:0]                     oACG_Command,
    output logic [2:0]                     oACG_CommandOption,
    output logic [NumberOfWays-1:0]        oACG_TargetWay,
    output logic [15:0]                    oACG_NumOfData,
    output logic                           oACG_CASelect,
    output logic [39:0]                    oACG_CAData,
    output logic [NumberOfCmds-1:0]        oOwner,
    output logic                           oDone,
    output logic                           oTimeout,
    output logic                           oUnknownCmd,
    output logic                           oConflict
);

    localparam int OwnerWidth = (NumberOfCmds > 1) ? $clog2(NumberOfCmds) : 1;
    // Watchdog fires when the counter reaches this value with no completion.
    localparam logic [15:0] TimeoutLimit = TimeoutCycles - 16'd1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StDrain = 2'd2
    } state_t;

    state_t                    state_r;
    logic [OwnerWidth-1:0]     owner_r;
    logic [NumberOfCmds-1:0]   owner_onehot_r;
    logic [15:0]               count_r;
    logic                      conflict_r;
    logic                      done_r;
    logic                      timeout_r;

    logic                      owner_last_s;
    logic [7:0]                sel_command_s;
    logic [2:0]                sel_option_s;
    logic [NumberOfWays-1:0]   sel_way_s;
    logic [15:0]               sel_numdata_s;
    logic                      sel_caselect_s;
    logic [39:0]               sel_cadata_s;

    // Index of the lowest set request bit.
    function automatic logic [OwnerWidth-1:0] lowest_index(input logic [NumberOfCmds-1:0] req);
        logic [OwnerWidth-1:0] idx;
        idx = {OwnerWidth{1'b0}};
        for (int k = NumberOfCmds - 1; k >= 0; k--) begin
            if (req[k]) begin
                idx = k[OwnerWidth-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot mask of the lowest set request bit.
    function automatic logic [NumberOfCmds-1:0] lowest_onehot(input logic [NumberOfCmds-1:0] req);
        return req & (~req + {{(NumberOfCmds-1){1'b0}}, 1'b1});
    endfunction

    // True when two or more request bits are set together.
    function automatic logic more_than_one(input logic [NumberOfCmds-1:0] req);
        return (req & (req - {{(NumberOfCmds-1){1'b0}}, 1'b1})) != {NumberOfCmds{1'b0}};
    endfunction

    assign owner_last_s = iLastStep[owner_r];

    // Arbiter FSM: grant, watchdog, completion and drain bookkeeping.
    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_r        <= StIdle;
            owner_r        <= {OwnerWidth{1'b0}};
            owner_onehot_r <= {NumberOfCmds{1'b0}};
            count_r        <= 16'd0;
            conflict_r     <= 1'b0;
            done_r         <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            case (state_r)
                StIdle: begin
                    if (|iStart) begin
                        state_r        <= StBusy;
                        owner_r        <= lowest_index(iStart);
                        owner_onehot_r <= lowest_onehot(iStart);
                        count_r        <= 16'd0;
                        conflict_r     <= conflict_r | more_than_one(iStart);
                    end else begin
                        state_r <= StIdle;
                    end
                end
                StBusy: begin
                    // Completion wins over a simultaneous watchdog expiry.
                    if (owner_last_s) begin
                        state_r        <= StDrain;
                        owner_onehot_r <= {NumberOfCmds{1'b0}};
                        done_r         <= 1'b1;
                    end else if (count_r == TimeoutLimit) begin
                        state_r        <= StDrain;
                        owner_onehot_r <= {NumberOfCmds{1'b0}};
                        timeout_r      <= 1'b1;
                    end else begin
                        count_r <= count_r + 16'd1;
                    end
                end
                StDrain: begin
                    state_r <= StIdle;
                end
                default: begin
                    state_r        <= StIdle;
                    owner_onehot_r <= {NumberOfCmds{1'b0}};
                end
            endcase
        end
    end

    // AND-OR mux of the owner's bundle; the one-hot mask is zero outside BUSY.
    always_comb begin
        sel_command_s  = 8'd0;
        sel_option_s   = 3'd0;
        sel_way_s      = {NumberOfWays{1'b0}};
        sel_numdata_s  = 16'd0;
        sel_caselect_s = 1'b0;
        sel_cadata_s   = 40'd0;
        for (int k = 0; k < NumberOfCmds; k++) begin
            sel_command_s  = sel_command_s  | ({8{owner_onehot_r[k]}}  & iCmd_Command[k*8 +: 8]);
            sel_option_s   = sel_option_s   | ({3{owner_onehot_r[k]}}  & iCmd_CommandOption[k*3 +: 3]);
            sel_way_s      = sel_way_s      | ({NumberOfWays{owner_onehot_r[k]}} & iCmd_TargetWay[k*NumberOfWays +: NumberOfWays]);
            sel_numdata_s  = sel_numdata_s  | ({16{owner_onehot_r[k]}} & iCmd_NumOfData[k*16 +: 16]);
            sel_caselect_s = sel_caselect_s | (owner_onehot_r[k] & iCmd_CASelect[k]);
            sel_cadata_s   = sel_cadata_s   | ({40{owner_onehot_r[k]}} & iCmd_CAData[k*40 +: 40]);
        end
    end

    assign oACG_Command       = sel_command_s;
    assign oACG_CommandOption = sel_option_s;
    assign oACG_TargetWay     = sel_way_s;
    assign oACG_NumOfData     = sel_numdata_s;
    // Idle value of CASelect is 1, so it is forced high outside BUSY.
    assign oACG_CASelect      = (state_r == StBusy) ? sel_caselect_s : 1'b1;
    assign oACG_CAData        = sel_cadata_s;

    assign oCMDReady   = (state_r == StIdle);
    assign oCMDValid   = {NumberOfCmds{iCMDValid & (state_r == StIdle)}};
    // Held low during reset even though ready/valid still pass through.
    assign oUnknownCmd = iReset_n & (state_r == StIdle) & iCMDValid & ~(|iStart);
    assign oOwner      = owner_onehot_r;
    assign oDone       = done_r;
    assign oTimeout    = timeout_r;
    assign oConflict   = conflict_r;

endmodule

// File: tb/tb_nfc_command_arbiter.sv
// Directed testbench for nfc_command_arbiter with hand-computed expectations.

module tb_nfc_command_arbiter;

    localparam int NW = 4;
    localparam int NC = 4;

    logic              iSystemClock = 1'b0;
    logic              iReset_n;
    logic              iCMDValid;
    logic              oCMDReady;
    logic [NC-1:0]     oCMDValid;
    logic [NC-1:0]     iStart;
    logic [NC-1:0]     iLastStep;
    logic [NC*8-1:0]   iCmd_Command;
    logic [NC*3-1:0]   iCmd_CommandOption;
    logic [NC*NW-1:0]  iCmd_TargetWay;
    logic [NC*16-1:0]  iCmd_NumOfData;
    logic [NC-1:0]     iCmd_CASelect;
    logic [NC*40-1:0]  iCmd_CAData;
    logic [7:0]        oACG_Command;
    logic [2:0]        oACG_CommandOption;
    logic [NW-1:0]     oACG_TargetWay;
    logic [15:0]       oACG_NumOfData;
    logic              oACG_CASelect;
    logic [39:0]       oACG_CAData;
    logic [NC-1:0]     oOwner;
    logic              oDone;
    logic              oTimeout;
    logic              oUnknownCmd;
    logic              oConflict;

    int nChecks = 0;
    int nFails  = 0;
    int busyCycles;

    nfc_command_arbiter #(
        .NumberOfWays (NW),
        .NumberOfCmds (NC),
        .TimeoutCycles(16'd16)
    ) dut (
        .iSystemClock      (iSystemClock),
        .iReset_n          (iReset_n),
        .iCMDValid         (iCMDValid),
        .oCMDReady         (oCMDReady),
        .oCMDValid         (oCMDValid),
        .iStart            (iStart),
        .iLastStep         (iLastStep),
        .iCmd_Command      (iCmd_Command),
        .iCmd_CommandOption(iCmd_CommandOption),
        .iCmd_TargetWay    (iCmd_TargetWay),
        .iCmd_NumOfData    (iCmd_NumOfData),
        .iCmd_CASelect     (iCmd_CASelect),
        .iCmd_CAData       (iCmd_CAData),
        .oACG_Command      (oACG_Command),
        .oACG_CommandOption(oACG_CommandOption),
        .oACG_TargetWay    (oACG_TargetWay),
        .oACG_NumOfData    (oACG_NumOfData),
        .oACG_CASelect     (oACG_CASelect),
        .oACG_CAData       (oACG_CAData),
        .oOwner            (oOwner),
        .oDone             (oDone),
        .oTimeout          (oTimeout),
        .oUnknownCmd       (oUnknownCmd),
        .oConflict         (oConflict)
    );

    always #5 iSystemClock = ~iSystemClock;

    task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge iSystemClock);
        #1;
    endtask

    task automatic clear_inputs();
        iCMDValid = 1'b0;
        iStart    = '0;
        iLastStep = '0;
    endtask

    initial begin
        // Per-module bundles: module k command A0+k, option k, way 1<<k,
        // numdata 0x100*(k+1), CASelect = k[0], distinct CAData patterns.
        iCmd_Command       = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        iCmd_CommandOption = {3'd3, 3'd2, 3'd1, 3'd0};
        iCmd_TargetWay     = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        iCmd_NumOfData     = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        iCmd_CASelect      = 4'b1010;
        iCmd_CAData        = {40'h30_31_32_33_34, 40'h60_00_00_00_00,
                              40'h20_21_22_23_24, 40'h10_11_12_13_14};

        // Reset state with a host command pending.
        iReset_n  = 1'b0;
        clear_inputs();
        iCMDValid = 1'b1;
        #2;
        check_value("rst_ready",    64'(oCMDReady),     64'd1);
        check_value("rst_valid",    64'(oCMDValid),     64'hF);
        check_value("rst_owner",    64'(oOwner),        64'd0);
        check_value("rst_unknown",  64'(oUnknownCmd),   64'd0);
        check_value("rst_conflict", 64'(oConflict),     64'd0);
        check_value("rst_caselect", 64'(oACG_CASelect), 64'd1);
        check_value("rst_cadata",   64'(oACG_CAData),   64'd0);
        tick();
        tick();
        iReset_n = 1'b1;

        // Unknown command: valid with no decoder.
        #1;
        check_value("unk_pulse", 64'(oUnknownCmd), 64'd1);
        check_value("unk_ready", 64'(oCMDReady),   64'd1);
        tick();
        clear_inputs();
        #1;
        check_value("unk_idle_ready", 64'(oCMDReady), 64'd1);
        check_value("unk_idle_owner", 64'(oOwner),    64'd0);
        check_value("unk_clear",      64'(oUnknownCmd), 64'd0);

        // Grant module 2, complete, drain, back to idle.
        iCMDValid = 1'b1;
        iStart    = 4'b0100;
        #1;
        check_value("g2_no_unknown", 64'(oUnknownCmd), 64'd0);
        tick();
        clear_inputs();
        iCMDValid = 1'b1;
        #1;
        check_value("g2_owner",   64'(oOwner),         64'b0100);
        check_value("g2_ready",   64'(oCMDReady),      64'd0);
        check_value("g2_valid",   64'(oCMDValid),      64'd0);
        check_value("g2_cadata",  64'(oACG_CAData),    64'h60_00_00_00_00);
        check_value("g2_command", 64'(oACG_Command),   64'hA2);
        check_value("g2_way",     64'(oACG_TargetWay), 64'b0100);
        check_value("g2_numdata", 64'(oACG_NumOfData), 64'h0300);
        check_value("g2_option",  64'(oACG_CommandOption), 64'd2);
        check_value("g2_casel",   64'(oACG_CASelect),  64'd0);
        check_value("g2_unknown_busy", 64'(oUnknownCmd), 64'd0);
        clear_inputs();
        iLastStep = 4'b0100;
        tick();
        clear_inputs();
        #1;
        check_value("g2_done",       64'(oDone),         64'd1);
        check_value("g2_drain_tmo",  64'(oTimeout),      64'd0);
        check_value("g2_drain_own",  64'(oOwner),        64'd0);
        check_value("g2_drain_rdy",  64'(oCMDReady),     64'd0);
        check_value("g2_drain_cas",  64'(oACG_CASelect), 64'd1);
        check_value("g2_drain_cad",  64'(oACG_CAData),   64'd0);
        tick();
        check_value("g2_idle_ready", 64'(oCMDReady), 64'd1);
        check_value("g2_idle_done",  64'(oDone),     64'd0);

        // Simultaneous starts: lowest index wins and conflict sticks.
        iStart = 4'b0110;
        tick();
        clear_inputs();
        #1;
        check_value("cf_owner",    64'(oOwner),       64'b0010);
        check_value("cf_flag",     64'(oConflict),    64'd1);
        check_value("cf_command",  64'(oACG_Command), 64'hA1);
        iLastStep = 4'b0010;
        tick();
        clear_inputs();
        tick();
        check_value("cf_sticky", 64'(oConflict), 64'd1);

        // Watchdog expiry with stray non-owner activity in the first BUSY cycle.
        iStart = 4'b0001;
        tick();
        clear_inputs();
        busyCycles = 0;
        while (oOwner != 4'b0000 && busyCycles < 40) begin
            busyCycles++;
            if (busyCycles == 1) begin
                iLastStep = 4'b1000;
                iStart    = 4'b1000;
                iCMDValid = 1'b1;
                #1;
                check_value("st_valid", 64'(oCMDValid), 64'd0);
                check_value("st_ready", 64'(oCMDReady), 64'd0);
            end else begin
                clear_inputs();
            end
            tick();
            if (busyCycles == 1) begin
                check_value("st_owner_kept", 64'(oOwner), 64'b0001);
            end else begin
                busyCycles = busyCycles;
            end
        end
        clear_inputs();
        check_value("to_busy_len", 64'(busyCycles), 64'd16);
        check_value("to_pulse",    64'(oTimeout),   64'd1);
        check_value("to_no_done",  64'(oDone),      64'd0);
        iLastStep = 4'b0001;
        tick();
        clear_inputs();
        check_value("to_single", 64'(oTimeout), 64'd0);
        check_value("to_ignored_done", 64'(oDone), 64'd0);
        check_value("to_idle_ready", 64'(oCMDReady), 64'd1);

        // Completion in the same cycle as expiry is a completion.
        iStart = 4'b1000;
        tick();
        clear_inputs();
        repeat (15) tick();
        check_value("tie_still_busy", 64'(oOwner), 64'b1000);
        iLastStep = 4'b1000;
        tick();
        clear_inputs();
        check_value("tie_done",    64'(oDone),    64'd1);
        check_value("tie_timeout", 64'(oTimeout), 64'd0);
        tick();

        // Asynchronous reset in the middle of BUSY.
        iStart = 4'b1000;
        tick();
        clear_inputs();
        check_value("ar_busy_owner", 64'(oOwner), 64'b1000);
        iReset_n = 1'b0;
        #1;
        check_value("ar_owner",    64'(oOwner),        64'd0);
        check_value("ar_ready",    64'(oCMDReady),     64'd1);
        check_value("ar_caselect", 64'(oACG_CASelect), 64'd1);
        check_value("ar_command",  64'(oACG_Command),  64'd0);
        check_value("ar_conflict", 64'(oConflict),     64'd0);
        tick();
        check_value("ar_no_done",    64'(oDone),    64'd0);
        check_value("ar_no_timeout", 64'(oTimeout), 64'd0);
        iReset_n  = 1'b1;
        iCMDValid = 1'b1;
        iStart    = 4'b0010;
        tick();
        clear_inputs();
        check_value("ar_regrant", 64'(oOwner),      64'b0010);
        check_value("ar_cadata",  64'(oACG_CAData), 64'h20_21_22_23_24);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/nfc_command_arbiter.md
NFC_COMMAND_ARBITER -- requirements
Module: nfc_command_arbiter

Interface
REQ-001 SHALL have parameter NumberOfWays, default 4, the NAND way-select width.
REQ-002 SHALL have parameter NumberOfCmds, default 4, the number of command modules sharing the ACG.
REQ-003 SHALL have parameter TimeoutCycles, default 16'hFFFF, the BUSY watchdog limit in clocks (width 16).
REQ-004 iSystemClock  in  1  the single clock; all state updates on its rising edge.
REQ-005 iReset_n  in  1  asynchronous, active-low reset.
REQ-006 iCMDValid  in  1  host command valid.
REQ-007 oCMDReady  out  1  host command ready.
REQ-008 oCMDValid  out  NumberOfCmds  per-module gated copy of iCMDValid.
REQ-009 iStart  in  NumberOfCmds  per-module decoded-start (oStart) flags.
REQ-010 iLastStep  in  NumberOfCmds  per-module completion pulses.
REQ-011 iCmd_Command / iCmd_CommandOption / iCmd_TargetWay / iCmd_NumOfData / iCmd_CASelect / iCmd_CAData  in  NumberOfCmds x {8, 3, NumberOfWays, 16, 1, 40}, packed with module k at slice k  per-module ACG bundles.
REQ-012 oACG_Command / oACG_CommandOption / oACG_TargetWay / oACG_NumOfData / oACG_CASelect / oACG_CAData  out  8 / 3 / NumberOfWays / 16 / 1 / 40  shared ACG bundle.
REQ-013 oOwner  out  NumberOfCmds  one-hot current grant; zero when not BUSY.
REQ-014 oDone  out  1  one-cycle pulse on normal completion.
REQ-015 oTimeout  out  1  one-cycle pulse on watchdog expiry.
REQ-016 oUnknownCmd  out  1  one-cycle pulse when a command is accepted but no module decodes it.
REQ-017 oConflict  out  1  sticky flag: more than one iStart bit was seen simultaneously.

Function
REQ-018 SHALL implement states IDLE, BUSY and DRAIN.
REQ-019 IDLE: oCMDReady=1; oCMDValid[k]=iCMDValid for all k; oACG bundle=idle value (all zero, CASelect=1).
REQ-020 IDLE with |iStart=1: latch owner = lowest set index; next state BUSY.
REQ-021 IDLE with iCMDValid=1 and iStart=0: pulse oUnknownCmd in the same cycle; remain in IDLE.
REQ-022 IDLE with more than one iStart bit set: set oConflict; it SHALL stay set until reset; grant per REQ-020.
REQ-023 BUSY: oCMDReady=0; oCMDValid=0; oACG bundle = owner's iCmd_* bundle via a combinational mux with zero cycle latency; oOwner=one-hot owner.
REQ-024 BUSY: iLastStep bits of non-owner modules SHALL be ignored.
REQ-025 BUSY with iLastStep[owner]=1: next state DRAIN; oDone pulses in the DRAIN cycle.
REQ-026 BUSY watchdog: 16-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-027 When the counter equals TimeoutCycles-1 and iLastStep[owner]=0: next state DRAIN; oTimeout pulses in the DRAIN cycle.
REQ-028 Completion and expiry in the same cycle SHALL be treated as completion: oDone=1, oTimeout=0.
REQ-029 DRAIN: lasts exactly 1 cycle; bundle=idle value; oCMDReady=0; oOwner=0; next state IDLE.
REQ-030 Minimum host turnaround SHALL be 3 cycles: accept cycle in IDLE, 1 BUSY cycle, DRAIN, then IDLE.
REQ-031 iACG_Ready, iACG_LastStep and iACG_ReadyBusy are not routed through this block; they SHALL be broadcast to all modules externally.
REQ-032 Owner index width SHALL be clog2(NumberOfCmds), minimum 1.

Reset
REQ-033 While iReset_n=0: state=IDLE, owner=0, counter=0, oConflict=0, oDone=0, oTimeout=0, oUnknownCmd=0, bundle=idle value; oCMDReady=1 and oCMDValid follow iCMDValid per REQ-019.
REQ-034 Reset assertion during BUSY SHALL abandon the grant immediately and asynchronously; no oDone or oTimeout pulse SHALL be generated.

Verification
REQ-035 iStart=4'b0100 with iCMDValid -> BUSY next cycle, oOwner=4'b0100, oACG_CAData equals module 2's 40'h60_00_00_00_00; iLastStep[2] -> oDone pulse, IDLE 2 cycles later.
REQ-036 iStart=4'b0110 -> owner=1, oConflict=1 and stays 1 across later commands until iReset_n=0.
REQ-037 iCMDValid=1 with iStart=0 -> oUnknownCmd=1 that cycle; oCMDReady remains 1; state stays IDLE.
REQ-038 TimeoutCycles=16 with no iLastStep -> DRAIN after 16 BUSY cycles, oTimeout single pulse, module inputs ignored afterwards.
REQ-039 During BUSY of module 0: iLastStep[3] and a new iStart=4'b1000 -> no effect; oCMDValid=0 and oCMDReady=0.
REQ-040 iReset_n low mid-BUSY -> outputs at reset values immediately; after release, the next command is granted normally.
